// File: rtl/leaky_relu_controller_if.sv
// rtl/leaky_relu_controller_if.sv - buffer read, leaky ReLU lane and write-back bundle
// master: controller side; slave: buffer/lane side.
interface leaky_relu_controller_if #(
    parameter int ADDR_W = 8
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [15:0]       rd_data_1_in;
    logic signed [15:0]       rd_data_2_in;

    logic                     lr_valid_1_out;
    logic                     lr_valid_2_out;
    logic signed [15:0]       lr_data_1_out;
    logic signed [15:0]       lr_data_2_out;
    logic signed [15:0]       lr_leak_factor_out;

    logic                     lr_valid_1_in;
    logic                     lr_valid_2_in;
    logic signed [15:0]       lr_data_1_in;
    logic signed [15:0]       lr_data_2_in;

    logic                     wr_en_1;
    logic                     wr_en_2;
    logic [ADDR_W-1:0]        wr_addr_1;
    logic [ADDR_W-1:0]        wr_addr_2;
    logic signed [15:0]       wr_data_1;
    logic signed [15:0]       wr_data_2;

    modport master (
        output rd_en, rd_addr,
        input  rd_data_1_in, rd_data_2_in,
        output lr_valid_1_out, lr_valid_2_out, lr_data_1_out, lr_data_2_out, lr_leak_factor_out,
        input  lr_valid_1_in, lr_valid_2_in, lr_data_1_in, lr_data_2_in,
        output wr_en_1, wr_en_2, wr_addr_1, wr_addr_2, wr_data_1, wr_data_2
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data_1_in, rd_data_2_in,
        input  lr_valid_1_out, lr_valid_2_out, lr_data_1_out, lr_data_2_out, lr_leak_factor_out,
        output lr_valid_1_in, lr_valid_2_in, lr_data_1_in, lr_data_2_in,
        input  wr_en_1, wr_en_2, wr_addr_1, wr_addr_2, wr_data_1, wr_data_2
    );
endinterface

// File: rtl/leaky_relu_controller.sv
// rtl/leaky_relu_controller.sv - two-lane leaky ReLU job controller (read, feed lanes, write back)
// Optional macro LR_CTRL_SKEW_EN: lane 2 runs one cycle behind lane 1.
module leaky_relu_controller #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        src_base_in,
    input  logic [ADDR_W-1:0]        dst_base_in,
    input  logic [CNT_W-1:0]         row_count_in,
    input  logic signed [15:0]       leak_factor_in,
    output logic                     busy,
    output logic                     done,
    leaky_relu_controller_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  src_base;
    logic [ADDR_W-1:0]  dst_base;
    logic [CNT_W-1:0]   row_count;
    logic [CNT_W-1:0]   rcnt;
    logic [CNT_W-1:0]   wcnt_1;
    logic [CNT_W-1:0]   wcnt_2;
    logic [CNT_W-1:0]   wcnt_1_nxt;
    logic [CNT_W-1:0]   wcnt_2_nxt;
    logic signed [15:0] leak;
    logic               v1;
    logic               accept;
    logic               active;
    logic               wr_1;
    logic               wr_2;

    assign accept = (state == IDLE) && start;
    assign active = (state == ISSUE) || (state == DRAIN);
    // Lane results are only written while a job is live and still owes rows.
    assign wr_1 = bus.lr_valid_1_in && active && (wcnt_1 != row_count);
    assign wr_2 = bus.lr_valid_2_in && active && (wcnt_2 != row_count);
    assign wcnt_1_nxt = wcnt_1 + CNT_W'(wr_1);
    assign wcnt_2_nxt = wcnt_2 + CNT_W'(wr_2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (row_count_in == '0) ? DONE : ISSUE;
            ISSUE:   if (rcnt == row_count - CNT_W'(1)) state_nxt = DRAIN;
            DRAIN:   if ((wcnt_1_nxt == row_count) && (wcnt_2_nxt == row_count)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_base  <= '0;
            dst_base  <= '0;
            row_count <= '0;
            leak      <= '0;
            rcnt      <= '0;
            wcnt_1    <= '0;
            wcnt_2    <= '0;
            v1        <= 1'b0;
        end else begin
            v1 <= (state == ISSUE);
            if (accept) begin
                src_base  <= src_base_in;
                dst_base  <= dst_base_in;
                row_count <= row_count_in;
                leak      <= leak_factor_in;
                rcnt      <= '0;
                wcnt_1    <= '0;
                wcnt_2    <= '0;
            end else begin
                if (state == ISSUE) rcnt <= rcnt + CNT_W'(1);
                wcnt_1 <= wcnt_1_nxt;
                wcnt_2 <= wcnt_2_nxt;
            end
        end
    end

`ifdef LR_CTRL_SKEW_EN
    logic               v2;
    logic signed [15:0] d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            d2 <= '0;
        end else begin
            v2 <= v1;
            d2 <= v1 ? bus.rd_data_2_in : 16'sd0;
        end
    end

    assign bus.lr_valid_2_out = v2;
    assign bus.lr_data_2_out  = d2;
`else
    assign bus.lr_valid_2_out = v1;
    assign bus.lr_data_2_out  = v1 ? bus.rd_data_2_in : 16'sd0;
`endif

    assign busy                   = (state != IDLE);
    assign done                   = (state == DONE);
    assign bus.rd_en              = (state == ISSUE);
    assign bus.rd_addr            = (state == ISSUE) ? src_base + ADDR_W'(rcnt) : '0;
    assign bus.lr_valid_1_out     = v1;
    assign bus.lr_data_1_out      = v1 ? bus.rd_data_1_in : 16'sd0;
    assign bus.lr_leak_factor_out = leak;

    assign bus.wr_en_1   = wr_1;
    assign bus.wr_en_2   = wr_2;
    assign bus.wr_addr_1 = wr_1 ? dst_base + ADDR_W'(wcnt_1) : '0;
    assign bus.wr_addr_2 = wr_2 ? dst_base + ADDR_W'(wcnt_2) : '0;
    assign bus.wr_data_1 = wr_1 ? bus.lr_data_1_in : 16'sd0;
    assign bus.wr_data_2 = wr_2 ? bus.lr_data_2_in : 16'sd0;
endmodule
